// File: rtl/hdma_engine.sv
`default_nettype none
// ============================================================================
// Module      : hdma_engine
// Description : Block-copy DMA engine with a Wishbone initiator port.
//               Copies (len+1) blocks of BLOCK_BYTES bytes from a source
//               address to a fixed destination window, one byte per
//               read/write pair. Optional H-blank mode copies one block per
//               rising edge of i_hblank and can be cancelled by software.
// Optional    : `define HDMA_HBLANK_MODE_EN enables H-blank mode
//               (CTRL[7], the HBWAIT state and cancel logic). When the macro
//               is undefined every transfer runs in general mode and
//               i_hblank is unused.
// Ports       : i_clk, i_rst_n       clock, async active-low reset
//               i_reg_we/sel/wdat    register write (0 SRC_HI, 1 SRC_LO,
//                                    2 DST_HI, 3 DST_LO, 4 CTRL)
//               o_reg_rdat           {active_n, remaining-1}
//               i_hblank             video H-blank level
//               o_cpu_halt           CPU stall request
//               o_cyc/o_stb/o_we/o_adr/o_dat, i_dat/i_ack/i_stall
//                                    Wishbone initiator (one outstanding)
// Revision    : 1.0  initial release
// ============================================================================
module hdma_engine #(
    parameter int          ADDR_W      = 16,
    parameter int          DATA_W      = 8,
    parameter int          BLOCK_BYTES = 16,
    parameter int          LEN_W       = 7,
    parameter logic [31:0] DST_BASE    = 32'h8000,
    parameter int          DST_SPAN_W  = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_reg_we,
    input  logic [2:0]        i_reg_sel,
    input  logic [7:0]        i_reg_wdat,
    output logic [7:0]        o_reg_rdat,
    input  logic              i_hblank,
    output logic              o_cpu_halt,
    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_adr,
    output logic [DATA_W-1:0] o_dat,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_ack,
    input  logic              i_stall
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int REM_W = LEN_W + 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_RD     = 3'd1;
    localparam logic [2:0] c_RDW    = 3'd2;
    localparam logic [2:0] c_WR     = 3'd3;
    localparam logic [2:0] c_WRW    = 3'd4;
    localparam logic [2:0] c_BLK    = 3'd5;
`ifdef HDMA_HBLANK_MODE_EN
    localparam logic [2:0] c_HBWAIT = 3'd6;
`endif

    localparam logic [ADDR_W-1:0]     c_ALIGN_A  = ~ADDR_W'(BLOCK_BYTES - 1);
    localparam logic [DST_SPAN_W-1:0] c_ALIGN_D  = ~DST_SPAN_W'(BLOCK_BYTES - 1);
    localparam logic [ADDR_W-1:0]     c_DST_BASE = ADDR_W'(DST_BASE);

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clocks after i_rst_n
    // rises so every state flop leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic [2:0]            r_state;
    logic [15:0]           r_src_cfg;
    logic [15:0]           r_dst_cfg;
    logic [ADDR_W-1:0]     r_src;
    logic [DST_SPAN_W-1:0] r_dst_off;
    logic [DATA_W-1:0]     r_data;
    logic [REM_W-1:0]      r_remaining;

    logic                  w_idle;
    logic                  w_ctrl_wr;
    logic                  w_start;
    logic                  w_last;
    logic [REM_W-1:0]      w_rem_dec;
    logic [REM_W-1:0]      w_rem_m1;
    logic [2:0]            w_first;
    logic [2:0]            w_blk_next;
    logic [2:0]            w_next;
    logic                  w_active_n;
    logic [ADDR_W-1:0]     w_dst_adr;
    logic                  w_unused_cfg;

    assign w_idle    = (r_state == c_IDLE);
    assign w_ctrl_wr = i_reg_we & (i_reg_sel == 3'd4);
    assign w_start   = w_ctrl_wr & w_idle;
    // Addresses stay block aligned, so the source low bits index the byte.
    assign w_last    = &r_src[OFF_W-1:0];
    assign w_rem_dec = r_remaining - REM_W'(1);
    assign w_rem_m1  = r_remaining - REM_W'(1);
    assign w_dst_adr = c_DST_BASE | ADDR_W'(r_dst_off);
    // Config bits above the address/window width are write-only storage.
    assign w_unused_cfg = ^{r_src_cfg, r_dst_cfg};

`ifdef HDMA_HBLANK_MODE_EN
    logic r_mode;
    logic r_cancel;
    logic r_hb_prev;
    logic r_hb_pend;
    logic w_hb_rise;
    logic w_cancel_wr;
    logic w_hb_go;

    assign w_hb_rise   = i_hblank & ~r_hb_prev;
    assign w_cancel_wr = w_ctrl_wr & ~w_idle & ~i_reg_wdat[7]
                       & ((r_state == c_HBWAIT) | r_mode);
    assign w_hb_go     = (r_hb_pend | w_hb_rise) & ~(r_cancel | w_cancel_wr);
    // H-blank already high at start: run the first block straight away.
    assign w_first     = (i_reg_wdat[7] & ~i_hblank) ? c_HBWAIT : c_RD;
    assign w_blk_next  = r_cancel ? c_IDLE : (r_mode ? c_HBWAIT : c_RD);
    // Between H-blank blocks the engine is off the bus and releases the CPU.
    assign w_active_n  = w_idle | (r_state == c_HBWAIT);

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mode    <= 1'b0;
            r_cancel  <= 1'b0;
            r_hb_prev <= 1'b0;
            r_hb_pend <= 1'b0;
        end else begin
            r_hb_prev <= i_hblank;
            if (w_start) begin
                r_mode   <= i_reg_wdat[7];
                r_cancel <= 1'b0;
            end else if (w_cancel_wr) begin
                r_cancel <= 1'b1;
            end
            // An edge seen mid-block (e.g. alongside the final ACK) is held
            // until HBWAIT consumes it.
            if (w_start || ((r_state == c_HBWAIT) && w_hb_go))
                r_hb_pend <= 1'b0;
            else if (w_hb_rise && !w_idle)
                r_hb_pend <= 1'b1;
        end
    end
`else
    logic w_unused_hblank;

    assign w_first         = c_RD;
    assign w_blk_next      = c_RD;
    assign w_active_n      = w_idle;
    assign w_unused_hblank = i_hblank;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_start) w_next = w_first;
            c_RD:     if (!i_stall) w_next = c_RDW;
            c_RDW:    if (i_ack) w_next = c_WR;
            c_WR:     if (!i_stall) w_next = c_WRW;
            c_WRW:    if (i_ack) w_next = w_last ? c_BLK : c_RD;
            c_BLK:    w_next = (w_rem_dec == '0) ? c_IDLE : w_blk_next;
`ifdef HDMA_HBLANK_MODE_EN
            c_HBWAIT: begin
                if (r_cancel || w_cancel_wr) w_next = c_IDLE;
                else if (w_hb_go)            w_next = c_RD;
            end
`endif
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= c_IDLE;
            r_src_cfg   <= '0;
            r_dst_cfg   <= '0;
            r_src       <= '0;
            r_dst_off   <= '0;
            r_data      <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle && i_reg_we) begin
                case (i_reg_sel)
                    3'd0:    r_src_cfg[15:8] <= i_reg_wdat;
                    3'd1:    r_src_cfg[7:0]  <= i_reg_wdat;
                    3'd2:    r_dst_cfg[15:8] <= i_reg_wdat;
                    3'd3:    r_dst_cfg[7:0]  <= i_reg_wdat;
                    default: ;
                endcase
            end
            if (w_start) begin
                r_src       <= ADDR_W'(r_src_cfg) & c_ALIGN_A;
                r_dst_off   <= DST_SPAN_W'(r_dst_cfg) & c_ALIGN_D;
                r_remaining <= REM_W'(i_reg_wdat[LEN_W-1:0]) + REM_W'(1);
            end
            if ((r_state == c_RDW) && i_ack)
                r_data <= i_dat;
            // Both pointers wrap naturally: src at ADDR_W, dst inside window.
            if ((r_state == c_WRW) && i_ack) begin
                r_src     <= r_src + ADDR_W'(1);
                r_dst_off <= r_dst_off + DST_SPAN_W'(1);
            end
            if (r_state == c_BLK)
                r_remaining <= w_rem_dec;
        end
    end

    assign o_cyc      = (r_state == c_RD) | (r_state == c_RDW)
                      | (r_state == c_WR) | (r_state == c_WRW);
    assign o_stb      = (r_state == c_RD) | (r_state == c_WR);
    assign o_we       = (r_state == c_WR);
    assign o_adr      = (r_state == c_RD) ? r_src
                      : ((r_state == c_WR) ? w_dst_adr : '0);
    assign o_dat      = (r_state == c_WR) ? r_data : '0;
    assign o_cpu_halt = ~w_active_n;
    // Signed cast keeps "0 remaining" reading as all ones for any LEN_W.
    assign o_reg_rdat = {w_active_n, 7'($signed(w_rem_m1))};

endmodule
`default_nettype wire

// File: tb/tb_hdma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdma_engine
// Description : Directed self-checking bench for hdma_engine with a small
//               Wishbone target (programmable stall and ACK delay) that logs
//               every accepted request.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hdma_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_we;
    logic [2:0]  reg_sel;
    logic [7:0]  reg_wdat;
    logic [7:0]  reg_rdat;
    logic        hblank;
    logic        cpu_halt;
    logic        cyc, stb, we;
    logic [15:0] adr;
    logic [7:0]  dat_o;
    logic [7:0]  dat_i;
    logic        ack;
    logic        stall;

    always #5 clk = ~clk;

    hdma_engine dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_reg_we   (reg_we),
        .i_reg_sel  (reg_sel),
        .i_reg_wdat (reg_wdat),
        .o_reg_rdat (reg_rdat),
        .i_hblank   (hblank),
        .o_cpu_halt (cpu_halt),
        .o_cyc      (cyc),
        .o_stb      (stb),
        .o_we       (we),
        .o_adr      (adr),
        .o_dat      (dat_o),
        .i_dat      (dat_i),
        .i_ack      (ack),
        .i_stall    (stall)
    );

    int          vectors;
    int          miscompares;
    int          stall_cfg, ack_dly, stall_cnt, ack_cnt;
    bit          pend;
    logic [15:0] hold_adr;
    logic [7:0]  hold_dat;
    int          unstable, halt_bad;
    logic [16:0] log_q[$];
    logic [7:0]  logd_q[$];

    function automatic logic [7:0] rd_data(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, then play the bus target.
    task automatic step();
        @(negedge clk);
        ack   = 1'b0;
        stall = 1'b0;
        if (cyc && !cpu_halt) halt_bad++;
        if (pend) begin
            if (ack_cnt == 0) begin
                ack  = 1'b1;
                pend = 1'b0;
            end else begin
                ack_cnt--;
            end
        end else if (stb) begin
            if (stall_cnt == 0) begin
                hold_adr = adr;
                hold_dat = dat_o;
            end else if (adr !== hold_adr || dat_o !== hold_dat) begin
                unstable++;
            end
            if (stall_cnt < stall_cfg) begin
                stall = 1'b1;
                stall_cnt++;
            end else begin
                stall_cnt = 0;
                pend      = 1'b1;
                ack_cnt   = ack_dly;
                log_q.push_back({we, adr});
                if (we) begin
                    logd_q.push_back(dat_o);
                end else begin
                    dat_i = rd_data(adr);
                    logd_q.push_back(dat_i);
                end
            end
        end
    endtask

    task automatic reg_wr(input logic [2:0] sel, input logic [7:0] d);
        reg_we   = 1'b1;
        reg_sel  = sel;
        reg_wdat = d;
        step();
        reg_we   = 1'b0;
    endtask

    task automatic set_ptrs(input logic [15:0] s, input logic [15:0] d);
        reg_wr(3'd0, s[15:8]);
        reg_wr(3'd1, s[7:0]);
        reg_wr(3'd2, d[15:8]);
        reg_wr(3'd3, d[7:0]);
        log_q.delete();
        logd_q.delete();
        halt_bad = 0;
        unstable = 0;
    endtask

    task automatic run_until_quiet(input int budget, input string tag);
        int n = 0;
        while (cpu_halt && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, {31'b0, cpu_halt}, 32'd0);
    endtask

    // rd0: aligned source; wr0: aligned destination address inside window.
    task automatic check_xfer(input int nbytes, input logic [15:0] rd0, input logic [15:0] wr0);
        for (int i = 0; i < nbytes; i++) begin
            logic [15:0] er;
            logic [15:0] ew;
            er = rd0 + 16'(i);
            ew = 16'h8000 | ((wr0 + 16'(i)) & 16'h1FFF);
            check($sformatf("rd_adr[%0d]", i), {15'b0, log_q[2*i]},   {15'b0, 1'b0, er});
            check($sformatf("wr_adr[%0d]", i), {15'b0, log_q[2*i+1]}, {15'b0, 1'b1, ew});
            check($sformatf("wr_dat[%0d]", i), {24'b0, logd_q[2*i+1]}, {24'b0, rd_data(er)});
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; reg_we = 1'b0; reg_sel = 3'd0; reg_wdat = 8'h00;
        hblank = 1'b0; dat_i = 8'h00; ack = 1'b0; stall = 1'b0;
        stall_cfg = 0; ack_dly = 0; stall_cnt = 0; ack_cnt = 0; pend = 1'b0;
        unstable = 0; halt_bad = 0;
        repeat (3) step();

        // Reset state
        check("rst_rdat", {24'b0, reg_rdat}, 32'hFF);
        check("rst_cyc",  {31'b0, cyc},      32'd0);
        check("rst_stb",  {31'b0, stb},      32'd0);
        check("rst_we",   {31'b0, we},       32'd0);
        check("rst_halt", {31'b0, cpu_halt}, 32'd0);
        check("rst_adr",  {16'b0, adr},      32'd0);
        check("rst_dato", {24'b0, dat_o},    32'd0);
        rst_n = 1'b1;
        repeat (4) step();
        check("idle_rdat", {24'b0, reg_rdat}, 32'hFF);

        // General mode, one block, zero-wait bus
        set_ptrs(16'h2000, 16'h8000);
        reg_wr(3'd4, 8'h00);
        check("gen_halt_start", {31'b0, cpu_halt}, 32'd1);
        run_until_quiet(400, "gen");
        check("gen_count", 32'(log_q.size()), 32'd32);
        check_xfer(16, 16'h2000, 16'h8000);
        check("gen_halt_gaps", 32'(halt_bad), 32'd0);
        check("gen_rdat", {24'b0, reg_rdat}, 32'hFF);

        // Alignment, window mapping and destination wrap
        set_ptrs(16'h1234, 16'hFFF7);
        reg_wr(3'd4, 8'h01);
        run_until_quiet(600, "wrap");
        check("wrap_count", 32'(log_q.size()), 32'd64);
        check("wrap_first_rd", {15'b0, log_q[0]},  {15'b0, 17'h01230});
        check("wrap_first_wr", {15'b0, log_q[1]},  {15'b0, 17'h19FF0});
        check("wrap_blk1_wr",  {15'b0, log_q[33]}, {15'b0, 17'h18000});
        check_xfer(32, 16'h1230, 16'h9FF0);
        check("wrap_rdat", {24'b0, reg_rdat}, 32'hFF);

        // Stalls and delayed ACK
        stall_cfg = 3; ack_dly = 2;
        set_ptrs(16'h2000, 16'h8000);
        reg_wr(3'd4, 8'h00);
        run_until_quiet(800, "stall");
        check("stall_count", 32'(log_q.size()), 32'd32);
        check_xfer(16, 16'h2000, 16'h8000);
        check("stall_stable", 32'(unstable), 32'd0);
        stall_cfg = 0; ack_dly = 0;

`ifdef HDMA_HBLANK_MODE_EN
        // H-blank mode, two blocks
        hblank = 1'b0;
        set_ptrs(16'h3000, 16'h8100);
        reg_wr(3'd4, 8'h81);
        check("hb_wait_halt", {31'b0, cpu_halt}, 32'd0);
        check("hb_wait_rdat", {24'b0, reg_rdat}, 32'h81);
        repeat (10) step();
        check("hb_no_stb", 32'(log_q.size()), 32'd0);
        hblank = 1'b1;
        step();
        check("hb_blk_halt", {31'b0, cpu_halt}, 32'd1);
        run_until_quiet(400, "hb_blk0");
        check("hb_blk0_count", 32'(log_q.size()), 32'd32);
        check("hb_between_rdat", {24'b0, reg_rdat}, 32'h80);
        repeat (10) step();
        check("hb_level_no_blk", 32'(log_q.size()), 32'd32);
        hblank = 1'b0;
        step();
        hblank = 1'b1;
        step();
        run_until_quiet(400, "hb_blk1");
        check("hb_count", 32'(log_q.size()), 32'd64);
        check_xfer(32, 16'h3000, 16'h8100);
        check("hb_rdat", {24'b0, reg_rdat}, 32'hFF);

        // Cancel during HBWAIT after the first of four blocks
        hblank = 1'b0;
        set_ptrs(16'h4000, 16'h8200);
        step();
        reg_wr(3'd4, 8'h83);
        hblank = 1'b1;
        step();
        run_until_quiet(400, "cancel_blk0");
        hblank = 1'b0;
        step();
        check("cancel_blk0_count", 32'(log_q.size()), 32'd32);
        check("cancel_wait_rdat", {24'b0, reg_rdat}, 32'h82);
        reg_wr(3'd4, 8'h00);
        step();
        hblank = 1'b1;
        repeat (20) step();
        check("cancel_no_more", 32'(log_q.size()), 32'd32);
        check("cancel_rdat", {24'b0, reg_rdat}, 32'h82);
        check("cancel_halt", {31'b0, cpu_halt}, 32'd0);
        hblank = 1'b0;
`else
        // CTRL[7] ignored: runs as a general two-block transfer
        hblank = 1'b0;
        set_ptrs(16'h3000, 16'h8100);
        reg_wr(3'd4, 8'h81);
        check("gen81_halt", {31'b0, cpu_halt}, 32'd1);
        run_until_quiet(600, "gen81");
        check("gen81_count", 32'(log_q.size()), 32'd64);
        check_xfer(32, 16'h3000, 16'h8100);
        check("gen81_rdat", {24'b0, reg_rdat}, 32'hFF);
`endif

        // Reset in the middle of block 0
        set_ptrs(16'h2000, 16'h8000);
        reg_wr(3'd4, 8'h00);
        for (int n = 0; n < 20 && log_q.size() < 2; n++) step();
        step();
        check("mid_pre_cyc", {31'b0, cyc}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc",  {31'b0, cyc},      32'd0);
        check("mid_rst_stb",  {31'b0, stb},      32'd0);
        check("mid_rst_halt", {31'b0, cpu_halt}, 32'd0);
        check("mid_rst_adr",  {16'b0, adr},      32'd0);
        ack = 1'b0; pend = 1'b0; stall_cnt = 0;
        repeat (3) step();
        rst_n = 1'b1;
        log_q.delete();
        logd_q.delete();
        repeat (10) step();
        check("post_rst_rdat", {24'b0, reg_rdat}, 32'hFF);
        check("post_rst_bus",  32'(log_q.size()), 32'd0);
        check("post_rst_cyc",  {31'b0, cyc},      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
